uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL clear immediately on rst=1, independent of clk.
REQ-002 Parameter DBIT, 8, data bits per frame.
REQ-003 Parameter SB_TICK, 16, stop-bit length in oversampling ticks.
REQ-004 Parameter DVSR, 54, clk cycles per oversampling tick (16 ticks per bit).
REQ-005 Parameter FIFO_W, 4, FIFO address width; depth = 2^FIFO_W = 16 words.
REQ-006 clk  input  1  system clock, rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 wr_uart  input  1  write strobe; one word is accepted per cycle when high and tx_full=0.
REQ-009 w_data  input  8  word to transmit, sampled with wr_uart.
REQ-010 tx_full  output  1  FIFO holds 2^FIFO_W words.
REQ-011 tx_empty  output  1  FIFO holds 0 words.
REQ-012 tx  output  1  serial line, idle high.
REQ-013 tx_done_tick  output  1  one-cycle pulse at the end of each frame's stop bit.

Function
REQ-014 Baud generator: free-running counter 0..DVSR-1; s_tick SHALL be high for one clk when the counter equals DVSR-1, then the counter wraps to 0.
REQ-015 FIFO: circular buffer with registered write/read pointers; full and empty SHALL be registered flags updated in the same cycle as pointer changes.
REQ-016 A write with tx_full=1 SHALL be dropped without disturbing contents, pointers or flags, even when a pop occurs in the same cycle.
REQ-017 A simultaneous write (tx_full=0) and pop SHALL advance both pointers and leave the occupancy unchanged.
REQ-018 A pop SHALL never occur when tx_empty=1.
REQ-019 Transmitter FSM states: IDLE, START, DATA, STOP.
REQ-020 IDLE: tx=1; if tx_empty=0, pop the head word into shift register b, clear the tick counter, go to START on the next clk.
REQ-021 START: tx=0 for 16 s_ticks, then clear the bit counter and go to DATA.
REQ-022 DATA: tx=b[0] for 16 s_ticks per bit; shift b right after each bit; after DBIT bits go to STOP. Data is sent LSB first.
REQ-023 STOP: tx=1 for SB_TICK s_ticks, then pulse tx_done_tick for one clk and return to IDLE.
REQ-024 Back-to-back: if the FIFO is non-empty on return to IDLE, the next pop SHALL occur one clk later; no extra idle bit is inserted.
REQ-025 Timing: the tick counter counts s_tick only; bit boundaries are aligned to s_tick, so the start-bit length SHALL be 16*DVSR clks, with up to DVSR-1 clks of phase offset.
REQ-026 tx SHALL be driven from a register (glitch-free).
REQ-027 Write-to-line latency with FIFO empty and FSM idle: word stored at edge N, popped at edge N+1, tx=0 from edge N+2.

Reset
REQ-028 On rst=1: tx=1, tx_full=0, tx_empty=1, tx_done_tick=0, FSM=IDLE, all pointers and counters=0; FIFO contents are don't-care.
REQ-029 Reset asserted mid-frame SHALL abort the frame (tx=1 immediately) and discard all queued words; after release, no frame starts until a new write.

Verification (DVSR=4, so bit = 64 clk, frame = 640 clk)
REQ-030 Single write 8'hA5 -> tx frame 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each bit 64 clk; one tx_done_tick; tx_empty=1 afterwards.
REQ-031 16 writes on consecutive clks while idle -> tx_full=0 after the first pop, no word lost; 16 contiguous frames with no idle gap; 16 tx_done_ticks.
REQ-032 17 writes issued while a frame is in progress and the FIFO is already holding words -> tx_full=1 after the 16th stored word; the 17th write is dropped; the dropped value never appears on tx.
REQ-033 Write on the same clk the FSM pops with the FIFO full -> write dropped; occupancy drops to 15; tx_full=0 the next clk.
REQ-034 rst pulse during DATA bit 3 of 8'h3C with 2 words queued -> tx=1 within the same cycle; tx_empty=1; line stays high for 1000 clk after release.
REQ-035 Write 8'h00 then 8'hFF -> frames line-checked bit-exact; tx_done_tick pulses spaced exactly 640 clk apart.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a 2^FIFO_W-word write FIFO. A free-running baud divider
// produces 16 oversampling ticks per bit. Frames are start bit, DBIT data bits LSB first, stop bit.
module uart_tx_fifo #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR    = 54,
   parameter int FIFO_W  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_uart,
   input  logic [7:0] w_data,
   output logic       tx_full,
   output logic       tx_empty,
   output logic       tx,
   output logic       tx_done_tick
);

   localparam int CW   = (DVSR > 1) ? $clog2(DVSR) : 1;
   localparam int TMAX = (SB_TICK > 16) ? SB_TICK : 16;
   localparam int TW   = $clog2(TMAX);
   localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [CW-1:0]     baud_q, baud_d;
   logic              s_tick;
   logic [7:0]        mem_q [2**FIFO_W];
   logic [FIFO_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              full_q, full_d, empty_q, empty_d;
   logic              push, pop;
   state_t            state_q;
   logic [TW-1:0]     s_cnt_q;
   logic [NW-1:0]     n_q;
   logic [7:0]        b_q;
   logic              tx_q, done_q;

   assign s_tick = (baud_q == CW'(DVSR - 1));

   always_comb begin
      baud_d = baud_q + 1'b1;
      if (s_tick) baud_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) baud_q <= '0;
      else     baud_q <= baud_d;
   end

   // A full FIFO drops the write even if the FSM pops in the same cycle.
   assign push = wr_uart && !full_q;
   assign pop  = (state_q == IDLE) && !empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      full_d   = full_q;
      empty_d  = empty_q;
      case ({push, pop})
         2'b10: begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            empty_d  = 1'b0;
            full_d   = (wr_ptr_d == rd_ptr_q);
         end
         2'b01: begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            full_d   = 1'b0;
            empty_d  = (rd_ptr_d == wr_ptr_q);
         end
         2'b11: begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= w_data;
   end

   // tx_q follows the state one clk late, so every bit keeps its full tick-aligned length.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         s_cnt_q <= '0;
         n_q     <= '0;
         b_q     <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (!empty_q) begin
                  b_q     <= mem_q[rd_ptr_q];
                  s_cnt_q <= '0;
                  state_q <= START;
               end
            end
            START: begin
               tx_q <= 1'b0;
               if (s_tick) begin
                  if (s_cnt_q == TW'(15)) begin
                     s_cnt_q <= '0;
                     n_q     <= '0;
                     state_q <= DATA;
                  end else begin
                     s_cnt_q <= s_cnt_q + 1'b1;
                  end
               end
            end
            DATA: begin
               tx_q <= b_q[0];
               if (s_tick) begin
                  if (s_cnt_q == TW'(15)) begin
                     s_cnt_q <= '0;
                     b_q     <= b_q >> 1;
                     if (n_q == NW'(DBIT - 1)) state_q <= STOP;
                     else                      n_q     <= n_q + 1'b1;
                  end else begin
                     s_cnt_q <= s_cnt_q + 1'b1;
                  end
               end
            end
            STOP: begin
               tx_q <= 1'b1;
               if (s_tick) begin
                  if (s_cnt_q == TW'(SB_TICK - 1)) begin
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     s_cnt_q <= s_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx           = tx_q;
   assign tx_done_tick = done_q;
   assign tx_full      = full_q;
   assign tx_empty     = empty_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with DVSR=4 (64 clk per bit, 640 clk per frame).
// A background line decoder samples each bit mid-period and logs frames and done pulses.
module tb_uart_tx_fifo;

   logic       clk;
   logic       rst;
   logic       wr_uart;
   logic [7:0] w_data;
   logic       tx_full;
   logic       tx_empty;
   logic       tx;
   logic       tx_done_tick;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0] rx_q[$];
   int         done_cyc[$];

   uart_tx_fifo #(.DBIT(8), .SB_TICK(16), .DVSR(4), .FIFO_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_uart      (wr_uart),
      .w_data       (w_data),
      .tx_full      (tx_full),
      .tx_empty     (tx_empty),
      .tx           (tx),
      .tx_done_tick (tx_done_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Frame decoder: t=0 is the first clk with tx low. Bit k is sampled at t = 32 + 64*k.
   initial begin
      int         st;
      int         t;
      logic [7:0] sh;
      st = 0;
      t  = 0;
      sh = '0;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (tx_done_tick) done_cyc.push_back(cyc);
         if (rst) begin
            st = 0;
         end else if (st == 0) begin
            if (tx == 1'b0) begin
               st = 1;
               t  = 0;
            end
         end else begin
            t++;
            if (t == 32) chk("start_bit", tx, 1'b0);
            else if (t > 32 && t < 608 && ((t - 32) % 64) == 0) sh = {tx, sh[7:1]};
            else if (t == 608) begin
               chk("stop_bit", tx, 1'b1);
               rx_q.push_back(sh);
               st = 0;
            end
         end
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] d);
      wr_uart = 1'b1;
      w_data  = d;
      step(1);
      wr_uart = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int k;
      k = 0;
      while (done_cyc.size() < target && k < budget) begin
         step(1);
         k++;
      end
      chk("done_timeout", 32'(done_cyc.size() >= target), 32'd1);
   endtask

   task automatic clear_logs();
      rx_q.delete();
      done_cyc.delete();
   endtask

   initial begin
      logic [7:0] fill [16];
      logic [7:0] burst [16];
      int         k;
      int         bad;

      #20000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] burst [16];
      logic [7:0] fill [16];
      int         k;
      int         bad;

      rst     = 1'b1;
      wr_uart = 1'b0;
      w_data  = '0;
      for (int i = 0; i < 16; i++) begin
         burst[i] = 8'(i * 17 + 3);
         fill[i]  = 8'(8'h80 + i);
      end

      step(3);
      chk("rst_tx", tx, 1'b1);
      chk("rst_empty", tx_empty, 1'b1);
      chk("rst_full", tx_full, 1'b0);
      chk("rst_done", tx_done_tick, 1'b0);
      rst = 1'b0;
      step(5);
      chk("idle_tx", tx, 1'b1);

      // Single word: latency to line and bit-exact frame.
      clear_logs();
      wr(8'hA5);
      chk("lat_n_empty", tx_empty, 1'b0);
      chk("lat_n_tx", tx, 1'b1);
      step(1);
      chk("lat_n1_tx", tx, 1'b1);
      chk("lat_n1_empty", tx_empty, 1'b1);
      step(1);
      chk("lat_n2_tx", tx, 1'b0);
      wait_done(1, 800);
      step(100);
      chk("a5_frames", rx_q.size(), 1);
      if (rx_q.size() >= 1) chk("a5_data", rx_q[0], 8'hA5);
      chk("a5_dones", done_cyc.size(), 1);
      chk("a5_empty", tx_empty, 1'b1);

      // 16 back-to-back writes from idle: never full, 16 contiguous frames.
      clear_logs();
      wr_uart = 1'b1;
      for (int i = 0; i < 16; i++) begin
         w_data = burst[i];
         step(1);
         chk("burst_full", tx_full, 1'b0);
      end
      wr_uart = 1'b0;
      wait_done(16, 16 * 640 + 700);
      step(50);
      chk("burst_frames", rx_q.size(), 16);
      for (int i = 0; i < 16 && i < rx_q.size(); i++) chk("burst_data", rx_q[i], burst[i]);
      for (int i = 1; i < done_cyc.size(); i++)
         chk("burst_gap", done_cyc[i] - done_cyc[i-1], 640);
      chk("burst_empty", tx_empty, 1'b1);

      // Fill to full during a frame; 17th write dropped; write during full pop dropped.
      clear_logs();
      wr(8'h11);
      step(4);
      wr_uart = 1'b1;
      for (int i = 0; i < 17; i++) begin
         w_data = (i == 16) ? 8'hEE : fill[i];
         step(1);
         if (i == 14) chk("fill15_full", tx_full, 1'b0);
         if (i == 15) chk("fill16_full", tx_full, 1'b1);
         if (i == 16) chk("fill17_full", tx_full, 1'b1);
      end
      wr_uart = 1'b0;
      k = 0;
      while (tx_done_tick !== 1'b1 && k < 800) begin
         step(1);
         k++;
      end
      chk("pop_wait", tx_done_tick, 1'b1);
      wr_uart = 1'b1;
      w_data  = 8'hDD;
      step(1);
      wr_uart = 1'b0;
      chk("pop_full", tx_full, 1'b0);
      chk("pop_empty", tx_empty, 1'b0);
      wait_done(17, 17 * 640 + 700);
      step(700);
      chk("fill_frames", rx_q.size(), 17);
      if (rx_q.size() >= 1) chk("fill_first", rx_q[0], 8'h11);
      for (int i = 1; i < 17 && i < rx_q.size(); i++) chk("fill_data", rx_q[i], fill[i-1]);
      chk("fill_dones", done_cyc.size(), 17);
      chk("fill_empty", tx_empty, 1'b1);

      // Async reset during data bit 3 of 8'h3C with two words queued.
      clear_logs();
      wr(8'h3C);
      wr(8'h55);
      wr(8'h66);
      step(288);
      chk("pre_rst_bit3", tx, 1'b1);
      chk("pre_rst_queue", tx_empty, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_tx", tx, 1'b1);
      chk("arst_empty", tx_empty, 1'b1);
      chk("arst_full", tx_full, 1'b0);
      @(posedge clk);
      #1;
      step(2);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         step(1);
         if (tx !== 1'b1) bad++;
         if (tx_empty !== 1'b1) bad++;
      end
      chk("post_rst_idle", bad, 0);
      chk("post_rst_frames", rx_q.size(), 0);
      chk("post_rst_dones", done_cyc.size(), 0);

      // 00 then FF: bit-exact frames, done pulses exactly one frame apart.
      clear_logs();
      wr(8'h00);
      wr(8'hFF);
      wait_done(2, 2 * 640 + 300);
      step(50);
      chk("edge_frames", rx_q.size(), 2);
      if (rx_q.size() >= 2) begin
         chk("edge_00", rx_q[0], 8'h00);
         chk("edge_ff", rx_q[1], 8'hFF);
      end
      if (done_cyc.size() >= 2) chk("edge_spacing", done_cyc[1] - done_cyc[0], 640);
      chk("edge_empty", tx_empty, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
